o_capture_writer: RTL
=====================

O_CAPTURE_WRITER -- requirements
Module: o_capture_writer

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 576, meaning visible pixels per line (multiple of 8).
REQ-002 SHALL have parameter V_VISIBLE, default 378, meaning visible lines per frame.
REQ-003 SHALL have parameter BYTES_PER_LINE, default 72, meaning H_VISIBLE/8.
REQ-004 SHALL have port O_CLK  in  1  scope pixel clock; single clock domain, all logic on its rising edge.
REQ-005 SHALL have port RESET  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ENABLE  in  1  capture enable.
REQ-007 SHALL have port O_X  in  10  visible-area x coordinate from the pixel counter.
REQ-008 SHALL have port O_Y  in  9  visible-area y coordinate from the pixel counter.
REQ-009 SHALL have port O_VISIBLE  in  1  pixel-valid qualifier, aligned with O_X, O_Y and O_PIXEL.
REQ-010 SHALL have port O_PIXEL  in  1  monochrome pixel value, 1 = lit.
REQ-011 SHALL have port WR_ADDR  out  16  frame-buffer byte address; bit 15 = bank, bits 14:0 = byte offset.
REQ-012 SHALL have port WR_DATA  out  8  packed pixel byte.
REQ-013 SHALL have port WR_EN  out  1  one-cycle write strobe.
REQ-014 SHALL have port FRAME_DONE  out  1  one-cycle pulse marking the last write of a complete frame.
REQ-015 SHALL have port RD_BANK  out  1  bank holding the most recent complete frame, for the VGA reader.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_FRAME, CAPTURE.
- IDLE -> WAIT_FRAME when ENABLE=1.
- Any state -> IDLE when ENABLE=0.
REQ-017 SHALL leave WAIT_FRAME for CAPTURE only on a cycle with O_VISIBLE=1, O_X=0, O_Y=0; that pixel is captured, and a partial frame after enable/reset is never written.
REQ-018 SHALL in CAPTURE shift O_PIXEL into an 8-bit packer on each O_VISIBLE=1 cycle with O_X<H_VISIBLE and O_Y<V_VISIBLE; pixel O_X[2:0]=0 lands in bit 7 (MSB first).
REQ-019 SHALL ignore O_VISIBLE=1 cycles with O_X>=H_VISIBLE or O_Y>=V_VISIBLE: no shift, no write.
REQ-020 SHALL, when a pixel with O_X[2:0]=7 is accepted, assert WR_EN on the next cycle with WR_DATA = completed byte and WR_ADDR[14:0] = O_Y*72 + O_X[9:3] (computed as (O_Y<<6)+(O_Y<<3)+O_X[9:3], 15-bit, no overflow for legal inputs); latency is exactly 1 cycle.
REQ-021 SHALL, if O_VISIBLE falls while the packer holds 1-7 bits, write the partial byte zero-padded in its low bits on the next cycle, at the address of the last accepted pixel.
REQ-022 SHALL drive WR_ADDR[15] = write bank = ~RD_BANK throughout CAPTURE.
REQ-023 SHALL assert FRAME_DONE in the same cycle as the WR_EN for pixel (H_VISIBLE-1, V_VISIBLE-1); RD_BANK toggles on the following cycle and the FSM returns to WAIT_FRAME.
REQ-024 SHALL, if ENABLE falls mid-frame, discard the packer, produce no further WR_EN or FRAME_DONE, and leave RD_BANK unchanged.
REQ-025 SHALL, on an O_VISIBLE=1, O_X=0, O_Y=0 cycle while already in CAPTURE (frame shortened), restart capture in the same bank without FRAME_DONE.
REQ-026 SHALL hold WR_EN and FRAME_DONE low outside CAPTURE, except the single trailing write of REQ-020/REQ-021.

Reset
REQ-027 SHALL on RESET=1 asynchronously set FSM=IDLE, WR_EN=0, FRAME_DONE=0, WR_DATA=0, WR_ADDR=0, RD_BANK=0 and packer count=0.
REQ-028 SHALL resume from IDLE on the first O_CLK edge after RESET deasserts.

Structure
REQ-029 SHALL take H_VISIBLE, V_VISIBLE, BYTES_PER_LINE and the frame-buffer address width from a shared package also used by the pixel counter and the VGA reader.
REQ-030 SHALL define the FSM state encoding locally.
REQ-031 SHALL be a single module; the address multiply SHALL stay inline as shift-add, with no sub-module.

Verification
REQ-032 Full frame of alternating pixels (O_PIXEL = O_X[0]) -> 27216 writes of WR_DATA=0x55, addresses 0x0000-0x6A4F, one FRAME_DONE with addr 0x6A4F, then RD_BANK=1.
REQ-033 Second identical frame -> writes at 0x8000-0xEA4F, RD_BANK returns to 0.
REQ-034 Enable mid-frame at O_Y=100 -> no writes until next O_X=0,O_Y=0; first write addr 0x0000.
REQ-035 O_VISIBLE drops after pixels 0-2 of a line, all lit -> one write, WR_DATA=0xE0.
REQ-036 ENABLE low at O_Y=200 -> WR_EN stays 0, no FRAME_DONE, RD_BANK unchanged.
REQ-037 RESET asserted mid-byte, asynchronously -> WR_EN=0 and RD_BANK=0 immediately, FSM=IDLE, no write of the partial byte.

Source files
------------

// File: rtl/o_capture_writer_pkg.sv
// Shared frame geometry for the scope capture path.
// Used by the pixel counter, the capture writer and the VGA reader.
package o_capture_writer_pkg;

    localparam int CAP_H_VISIBLE      = 576;
    localparam int CAP_V_VISIBLE      = 378;
    localparam int CAP_BYTES_PER_LINE = CAP_H_VISIBLE / 8;
    localparam int CAP_FB_ADDR_W      = 16;

endpackage

// File: rtl/o_capture_writer.sv
// Packs visible monochrome pixels into bytes and writes whole frames
// into a double-buffered frame store, flipping RD_BANK per frame.
module o_capture_writer
    import o_capture_writer_pkg::*;
#(
    parameter int H_VISIBLE      = CAP_H_VISIBLE,
    parameter int V_VISIBLE      = CAP_V_VISIBLE,
    parameter int BYTES_PER_LINE = CAP_BYTES_PER_LINE
) (
    input  logic                     O_CLK,
    input  logic                     RESET,
    input  logic                     ENABLE,
    input  logic [9:0]               O_X,
    input  logic [8:0]               O_Y,
    input  logic                     O_VISIBLE,
    input  logic                     O_PIXEL,
    output logic [CAP_FB_ADDR_W-1:0] WR_ADDR,
    output logic [7:0]               WR_DATA,
    output logic                     WR_EN,
    output logic                     FRAME_DONE,
    output logic                     RD_BANK
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } state_e;

    localparam logic [9:0] H_LIM      = 10'(H_VISIBLE);
    localparam logic [8:0] V_LIM      = 9'(V_VISIBLE);
    localparam logic [8:0] Y_LAST     = 9'(V_VISIBLE - 1);
    localparam logic [6:0] X_LAST_COL = 7'(BYTES_PER_LINE - 1);

    state_e state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [14:0] last_addr_q, last_addr_d;
    logic wr_en_q, wr_en_d;
    logic done_q, done_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [CAP_FB_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic rd_bank_q, rd_bank_d;

    logic start;
    logic in_range;
    logic last_px;
    logic accept;
    logic restart;
    logic [14:0] pix_addr;
    logic [7:0] sr_base;
    logic [2:0] cnt_base;
    logic [7:0] byte_v;

    assign start    = O_VISIBLE && (O_X == 10'd0) && (O_Y == 9'd0);
    assign in_range = O_VISIBLE && (O_X < H_LIM) && (O_Y < V_LIM);
    assign last_px  = (O_X[9:3] == X_LAST_COL) && (O_X[2:0] == 3'd7)
                      && (O_Y == Y_LAST);

    // y*72 + x/8 as shift-add
    assign pix_addr = {O_Y, 6'd0} + {3'd0, O_Y, 3'd0} + {8'd0, O_X[9:3]};

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        last_addr_d = last_addr_q;
        wr_en_d     = 1'b0;
        done_d      = 1'b0;
        wr_data_d   = wr_data_q;
        wr_addr_d   = wr_addr_q;
        // the bank flip lands one cycle after FRAME_DONE
        rd_bank_d   = rd_bank_q ^ done_q;
        accept      = 1'b0;
        restart     = 1'b0;

        if (!ENABLE) begin
            state_d = IDLE;
            sr_d    = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_FRAME;
                WAIT_FRAME: begin
                    if (start) begin
                        state_d = CAPTURE;
                        accept  = 1'b1;
                        restart = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (start) begin
                        accept  = 1'b1;
                        restart = 1'b1;
                    end else if (in_range) begin
                        accept = 1'b1;
                    end else if (!O_VISIBLE && cnt_q != 3'd0) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = sr_q << (4'd8 - {1'b0, cnt_q});
                        wr_addr_d = {~rd_bank_d, last_addr_q};
                        sr_d      = '0;
                        cnt_d     = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        sr_base  = restart ? 8'd0 : sr_q;
        cnt_base = restart ? 3'd0 : cnt_q;
        byte_v   = {sr_base[6:0], O_PIXEL};

        if (accept) begin
            last_addr_d = pix_addr;
            if (O_X[2:0] == 3'd7) begin
                wr_en_d   = 1'b1;
                wr_data_d = byte_v;
                wr_addr_d = {~rd_bank_d, pix_addr};
                sr_d      = '0;
                cnt_d     = '0;
                if (last_px) begin
                    done_d  = 1'b1;
                    state_d = WAIT_FRAME;
                end
            end else begin
                sr_d  = byte_v;
                cnt_d = cnt_base + 3'd1;
            end
        end
    end

    always_ff @(posedge O_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            last_addr_q <= '0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            rd_bank_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            last_addr_q <= last_addr_d;
            wr_en_q     <= wr_en_d;
            done_q      <= done_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            rd_bank_q   <= rd_bank_d;
        end
    end

    assign WR_ADDR    = wr_addr_q;
    assign WR_DATA    = wr_data_q;
    assign WR_EN      = wr_en_q;
    assign FRAME_DONE = done_q;
    assign RD_BANK    = rd_bank_q;

endmodule
